read_control_top_1: RTL and testbench
=====================================

Name: read_control_top_1

Overview:
Read-side pointer and status controller for the dual-clock FIFO. It pairs with the write controller on the other end of the FIFO RAM.
- Advances the read pointer on accepted reads and drives the RAM read address.
- Publishes a Gray-coded read pointer for the write domain.
- Synchronises the incoming Gray write pointer into rd_clk and derives empty, almost-empty, read-valid and underflow status.

Parameters:
ADDR_W, 4 (equals shared `a_length), RAM address width; FIFO depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
AE_THRESH, 2, f_almost_empty asserts when occupancy <= AE_THRESH.

Ports:
rd_clk  input  1  read-domain clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
rd_en  input  1  read request from the consumer.
wr_ptr_gray  input  ADDR_W+1  Gray write pointer from the write domain (asynchronous to rd_clk).
f_empty  output  1  FIFO empty, registered.
f_almost_empty  output  1  occupancy <= AE_THRESH, registered.
rd_valid  output  1  one-cycle pulse, one rd_clk after an accepted read; RAM data valid.
rd_underflow  output  1  one-cycle pulse when rd_en arrives while f_empty=1.
MSB_rd_ptr  output  1  wrap bit, rd_ptr[ADDR_W].
rd_ptr  output  ADDR_W+1  binary read pointer, registered.
b_rd_ptr  output  ADDR_W  RAM read address, rd_ptr[ADDR_W-1:0].
rd_ptr_gray  output  ADDR_W+1  registered Gray read pointer for the write-domain synchroniser.

Behaviour:
- Reset (asynchronous, takes effect immediately, no clock needed):
  - rd_ptr=0, rd_ptr_gray=0, both synchroniser stages=0.
  - f_empty=1, f_almost_empty=1, rd_valid=0, rd_underflow=0.
- Accept rule: rd_inc = rd_en & ~f_empty, using the registered f_empty.
- Pointer update:
  - rd_ptr_next = rd_ptr + rd_inc, modulo 2^(ADDR_W+1).
  - At each edge: rd_ptr <= rd_ptr_next; rd_ptr_gray <= bin2gray(rd_ptr_next).
  - Wrap 2^(ADDR_W+1)-1 -> 0 is natural rollover; MSB_rd_ptr toggles on every RAM-address wrap.
- Synchroniser: wsync1 <= wr_ptr_gray; wsync2 <= wsync1. No logic between the stages.
- Empty flag: f_empty <= (bin2gray(rd_ptr_next) == wsync2). It is computed from the next pointer, so the last read asserts empty on the same edge the pointer advances.
- Occupancy:
  - count = gray2bin(wsync2) - rd_ptr_next, modulo 2^(ADDR_W+1). Range 0..2^ADDR_W.
  - f_almost_empty <= (count <= AE_THRESH).
- rd_valid <= rd_inc. This is fixed 1-cycle read latency, matching the registered RAM output.
- rd_underflow <= rd_en & f_empty. Pointer unchanged; no sticky state.
- Write-to-read visibility:
  - After a wr_ptr_gray change, f_empty can deassert no earlier than the 3rd rd_clk rising edge (two sync stages plus one flag register).
  - Empty is pessimistic: it may stay asserted longer, but it never deasserts falsely.
- Driver requirement: wr_ptr_gray changes at most one bit per wr_clk and comes straight from a register.
- Simultaneous write arrival and last read: the read is accepted. f_empty follows the compare against the current wsync2, so newly synchronised data clears empty on that edge.
- Reset mid-operation: any in-flight rd_valid is dropped, and the pointers return to 0.

Decomposition:
- Shared header para.h:
  - `a_length (default for ADDR_W).
  - AE_THRESH default.
  - bin2gray and gray2bin functions, shared with the write controller.
- One sub-module: ptr_sync_2ff. It is a parameterised-width two-flop synchroniser with asynchronous active-high reset. The write side reuses it for rd_ptr_gray.
- Pointer counter is inline, because rd_ptr_next is needed combinationally.

Test Plan:
- Reset: pulse reset between clock edges with rd_ptr=7 -> immediately rd_ptr=0, rd_ptr_gray=0, f_empty=1, f_almost_empty=1, rd_valid=0.
- Empty read: wr_ptr_gray=0, rd_en=1 for 3 cycles -> rd_ptr stays 0, rd_underflow=1 each cycle, rd_valid=0.
- Visibility: wr_ptr_gray 00000->00001 -> f_empty=0 after the 3rd rd_clk edge. Then rd_en=1 for one cycle -> rd_ptr=1, rd_ptr_gray=00001, f_empty=1 on the same edge, rd_valid=1 on the next cycle only.
- Wrap: wr_ptr_gray advanced as a Gray sequence to bin 0 after 32 writes, with continuous reads -> rd_ptr goes 31->0, b_rd_ptr 15->0, MSB_rd_ptr 1->0, rd_ptr_gray 10000->00000, f_empty=1 at the end.
- Almost-empty: wr bin=5, rd_ptr=0 -> f_almost_empty=0. After 3 reads (count=2) -> f_almost_empty=1 on the edge of the 3rd read.
- Full depth: wr bin=16, rd_ptr=0 -> count=16, f_empty=0. 16 reads -> exactly 16 rd_valid pulses, f_empty=1, no rd_underflow.

Source files
------------

// File: rtl/read_control_top_1_pkg.sv
`default_nettype none
// ============================================================================
// Module : read_control_top_1_pkg
// Brief  : Shared FIFO constants and Gray/binary conversion helpers.
// Rev    : 1.0
// ============================================================================
package read_control_top_1_pkg;

    localparam int A_LENGTH          = 4;
    localparam int AE_THRESH_DEFAULT = 2;
    localparam int CONV_W            = 32;

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR by doubling shifts; callers zero-extend narrower pointers.
    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
        logic [CONV_W-1:0] b;
        b = g;
        for (int s = 1; s < CONV_W; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/read_control_top_1_ptr_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module : ptr_sync_2ff
// Brief  : Two-flop synchroniser for Gray pointers crossing clock domains.
// Rev    : 1.0
// ============================================================================
module ptr_sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign q_o = sync2_q;

endmodule
`default_nettype wire

// File: rtl/read_control_top_1.sv
`default_nettype none
// ============================================================================
// Module : read_control_top_1
// Brief  : Dual-clock FIFO read-side pointer and empty/almost-empty control.
// Rev    : 1.0
// ============================================================================
module read_control_top_1
    import read_control_top_1_pkg::*;
#(
    parameter int ADDR_W    = A_LENGTH,
    parameter int AE_THRESH = AE_THRESH_DEFAULT
) (
    input  logic              rd_clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wr_ptr_gray,
    output logic              f_empty,
    output logic              f_almost_empty,
    output logic              rd_valid,
    output logic              rd_underflow,
    output logic              MSB_rd_ptr,
    output logic [ADDR_W:0]   rd_ptr,
    output logic [ADDR_W-1:0] b_rd_ptr,
    output logic [ADDR_W:0]   rd_ptr_gray
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW-1:0] rd_gray_q;
    logic [PW-1:0] rd_gray_d;
    logic [PW-1:0] wsync2;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] count;
    logic          rd_inc;
    logic          f_empty_q;
    logic          f_ae_q;
    logic          rd_valid_q;
    logic          rd_uf_q;

    ptr_sync_2ff #(
        .WIDTH(PW)
    ) u_wptr_sync (
        .clk (rd_clk),
        .rst (reset),
        .d_i (wr_ptr_gray),
        .q_o (wsync2)
    );

    // Flags are evaluated against the next pointer so the final read sets empty on its own edge.
    always_comb begin
        rd_inc    = rd_en & ~f_empty_q;
        rd_ptr_d  = rd_ptr_q + PW'(rd_inc);
        rd_gray_d = PW'(bin2gray(CONV_W'(rd_ptr_d)));
        wr_bin    = PW'(gray2bin(CONV_W'(wsync2)));
        count     = wr_bin - rd_ptr_d;
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            rd_gray_q  <= '0;
            f_empty_q  <= 1'b1;
            f_ae_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_uf_q    <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            rd_gray_q  <= rd_gray_d;
            f_empty_q  <= (rd_gray_d == wsync2);
            f_ae_q     <= (count <= PW'(AE_THRESH));
            rd_valid_q <= rd_inc;
            rd_uf_q    <= rd_en & f_empty_q;
        end
    end

    assign rd_ptr         = rd_ptr_q;
    assign rd_ptr_gray    = rd_gray_q;
    assign b_rd_ptr       = rd_ptr_q[ADDR_W-1:0];
    assign MSB_rd_ptr     = rd_ptr_q[ADDR_W];
    assign f_empty        = f_empty_q;
    assign f_almost_empty = f_ae_q;
    assign rd_valid       = rd_valid_q;
    assign rd_underflow   = rd_uf_q;

endmodule
`default_nettype wire

// File: tb/tb_read_control_top_1.sv
`default_nettype none
// ============================================================================
// Module : tb_read_control_top_1
// Brief  : Self-checking bench for the FIFO read controller.
// Rev    : 1.0
// ============================================================================
module tb_read_control_top_1;

    logic       rd_clk;
    logic       reset;
    logic       rd_en;
    logic [4:0] wr_ptr_gray;
    logic       f_empty;
    logic       f_almost_empty;
    logic       rd_valid;
    logic       rd_underflow;
    logic       MSB_rd_ptr;
    logic [4:0] rd_ptr;
    logic [3:0] b_rd_ptr;
    logic [4:0] rd_ptr_gray;

    int checks;
    int errors;
    int w_bin;

    read_control_top_1 #(
        .ADDR_W   (4),
        .AE_THRESH(2)
    ) dut (
        .rd_clk        (rd_clk),
        .reset         (reset),
        .rd_en         (rd_en),
        .wr_ptr_gray   (wr_ptr_gray),
        .f_empty       (f_empty),
        .f_almost_empty(f_almost_empty),
        .rd_valid      (rd_valid),
        .rd_underflow  (rd_underflow),
        .MSB_rd_ptr    (MSB_rd_ptr),
        .rd_ptr        (rd_ptr),
        .b_rd_ptr      (b_rd_ptr),
        .rd_ptr_gray   (rd_ptr_gray)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // Reference model: integer pointers plus a two-deep delay line of observed write pointers.
    function automatic int g2b(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return int'(b);
    endfunction

    function automatic logic [4:0] b2g(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ {1'b0, v[4:1]};
    endfunction

    int         m_rd;
    logic [4:0] m_s1, m_s2;
    logic       m_empty, m_ae, m_valid, m_uf;
    logic       m_inc;
    int         m_next, m_wb, m_cnt;

    always_comb begin
        m_inc  = rd_en & ~m_empty;
        m_next = (m_rd + (m_inc ? 1 : 0)) % 32;
        m_wb   = g2b(m_s2);
        m_cnt  = (m_wb - m_next + 32) % 32;
    end

    always @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            m_rd <= 0; m_s1 <= '0; m_s2 <= '0;
            m_empty <= 1'b1; m_ae <= 1'b1; m_valid <= 1'b0; m_uf <= 1'b0;
        end else begin
            m_rd    <= m_next;
            m_s1    <= wr_ptr_gray;
            m_s2    <= m_s1;
            m_empty <= (m_next == m_wb);
            m_ae    <= (m_cnt <= 2);
            m_valid <= m_inc;
            m_uf    <= rd_en & m_empty;
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        @(negedge rd_clk);
    endtask

    task automatic set_wr(input int b);
        w_bin = b % 32;
        wr_ptr_gray = b2g(w_bin);
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_en = 1'b0; set_wr(0);
        #12;
        checks++;
        if (rd_ptr !== 5'd0 || rd_ptr_gray !== 5'd0 || f_empty !== 1'b1 ||
            f_almost_empty !== 1'b1 || rd_valid !== 1'b0 || rd_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ptr=%0d gray=%b e=%b ae=%b v=%b uf=%b required 0 00000 1 1 0 0",
                     rd_ptr, rd_ptr_gray, f_empty, f_almost_empty, rd_valid, rd_underflow);
        end
        @(negedge rd_clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_empty_read();
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rd_ptr !== 5'd0 || rd_underflow !== 1'b1 || rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty_read[%0d]: ptr=%0d uf=%b v=%b required 0 1 0", i, rd_ptr, rd_underflow, rd_valid);
            end
        end
        rd_en = 1'b0;
        tick();
        checks++;
        if (rd_underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: uf=%b required 0", rd_underflow);
        end
    endtask

    task automatic test_visibility();
        set_wr(1);
        tick(); tick();
        checks++;
        if (f_empty !== 1'b1) begin
            errors++;
            $display("FAIL vis_early: f_empty=%b required 1 after 2 edges", f_empty);
        end
        tick();
        checks++;
        if (f_empty !== 1'b0) begin
            errors++;
            $display("FAIL vis_3rd: f_empty=%b required 0 after 3 edges", f_empty);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_ptr !== 5'd1 || rd_ptr_gray !== 5'b00001 || f_empty !== 1'b1 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL last_read: ptr=%0d gray=%b e=%b v=%b required 1 00001 1 1",
                     rd_ptr, rd_ptr_gray, f_empty, rd_valid);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_ptr !== 5'd1) begin
            errors++;
            $display("FAIL valid_pulse: v=%b ptr=%0d required 0 1", rd_valid, rd_ptr);
        end
    endtask

    task automatic test_almost_empty();
        for (int b = 2; b <= 6; b++) begin
            set_wr(b);
            tick();
        end
        tick(); tick(); tick();
        checks++;
        if (f_almost_empty !== 1'b0 || f_empty !== 1'b0) begin
            errors++;
            $display("FAIL ae_count5: ae=%b e=%b required 0 0", f_almost_empty, f_empty);
        end
        rd_en = 1'b1;
        tick(); tick();
        checks++;
        if (f_almost_empty !== 1'b0) begin
            errors++;
            $display("FAIL ae_count3: ae=%b required 0", f_almost_empty);
        end
        tick();
        checks++;
        if (f_almost_empty !== 1'b1 || f_empty !== 1'b0) begin
            errors++;
            $display("FAIL ae_count2: ae=%b e=%b required 1 0", f_almost_empty, f_empty);
        end
        tick(); tick();
        rd_en = 1'b0;
        checks++;
        if (f_empty !== 1'b1 || rd_ptr !== 5'd6) begin
            errors++;
            $display("FAIL ae_drain: e=%b ptr=%0d required 1 6", f_empty, rd_ptr);
        end
    endtask

    task automatic test_full_depth();
        int nv, nu;
        nv = 0; nu = 0;
        for (int i = 1; i <= 16; i++) begin
            set_wr(6 + i);
            tick();
        end
        tick(); tick(); tick();
        checks++;
        if (f_empty !== 1'b0 || f_almost_empty !== 1'b0) begin
            errors++;
            $display("FAIL full_flags: e=%b ae=%b required 0 0", f_empty, f_almost_empty);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            nv += rd_valid ? 1 : 0;
            nu += rd_underflow ? 1 : 0;
        end
        rd_en = 1'b0;
        tick();
        nv += rd_valid ? 1 : 0;
        checks++;
        if (nv != 16 || nu != 0 || f_empty !== 1'b1 || rd_ptr !== 5'd22) begin
            errors++;
            $display("FAIL full_drain: valids=%0d uf=%0d e=%b ptr=%0d required 16 0 1 22",
                     nv, nu, f_empty, rd_ptr);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] pp, pg;
        logic [3:0] pb;
        logic       pm;
        bit         seen;
        seen = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (w_bin != 0) set_wr(w_bin + 1);
            pp = rd_ptr; pg = rd_ptr_gray; pb = b_rd_ptr; pm = MSB_rd_ptr;
            tick();
            if (pp == 5'd31 && rd_ptr == 5'd0) begin
                seen = 1'b1;
                checks++;
                if (pb !== 4'd15 || b_rd_ptr !== 4'd0 || pm !== 1'b1 || MSB_rd_ptr !== 1'b0 ||
                    pg !== 5'b10000 || rd_ptr_gray !== 5'b00000) begin
                    errors++;
                    $display("FAIL wrap_edge: b %0d->%0d msb %b->%b gray %b->%b required 15->0 1->0 10000->00000",
                             pb, b_rd_ptr, pm, MSB_rd_ptr, pg, rd_ptr_gray);
                end
            end
        end
        rd_en = 1'b0;
        checks++;
        if (!seen || rd_ptr !== 5'd0 || rd_ptr_gray !== 5'd0 || f_empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_end: seen=%0d ptr=%0d gray=%b e=%b required 1 0 00000 1",
                     seen, rd_ptr, rd_ptr_gray, f_empty);
        end
    endtask

    task automatic test_random();
        int occ;
        for (int i = 0; i < 400; i++) begin
            rd_en = ($urandom_range(0, 99) < 55);
            occ = (w_bin - m_rd + 32) % 32;
            if (occ < 16 && $urandom_range(0, 99) < 50) set_wr(w_bin + 1);
            tick();
            checks++;
            if (rd_ptr !== 5'(m_rd) || rd_ptr_gray !== b2g(m_rd) || b_rd_ptr !== 4'(m_rd % 16) ||
                MSB_rd_ptr !== (m_rd >= 16) || f_empty !== m_empty || f_almost_empty !== m_ae ||
                rd_valid !== m_valid || rd_underflow !== m_uf) begin
                errors++;
                $display("FAIL random[%0d]: ptr=%0d gray=%b e=%b ae=%b v=%b uf=%b required %0d %b %b %b %b %b",
                         i, rd_ptr, rd_ptr_gray, f_empty, f_almost_empty, rd_valid, rd_underflow,
                         m_rd, b2g(m_rd), m_empty, m_ae, m_valid, m_uf);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        set_wr(0);
        #3;
        @(negedge rd_clk);
        reset = 1'b0;
        for (int b = 1; b <= 9; b++) begin
            set_wr(b);
            tick();
        end
        tick(); tick(); tick();
        rd_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        @(posedge rd_clk);
        #1;
        checks++;
        if (rd_ptr !== 5'd7 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: ptr=%0d v=%b required 7 1", rd_ptr, rd_valid);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (rd_ptr !== 5'd0 || rd_ptr_gray !== 5'd0 || f_empty !== 1'b1 ||
            f_almost_empty !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ptr=%0d gray=%b e=%b ae=%b v=%b required 0 00000 1 1 0",
                     rd_ptr, rd_ptr_gray, f_empty, f_almost_empty, rd_valid);
        end
        @(negedge rd_clk);
        rd_en = 1'b0;
        set_wr(0);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        w_bin  = 0;
        rd_en  = 1'b0;
        reset  = 1'b0;
        wr_ptr_gray = '0;
        test_reset();
        test_empty_read();
        test_visibility();
        test_almost_empty();
        test_full_depth();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
